// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM configuration loader.
package pwm_pkg;
    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_MIN_PERIOD = 2;

    typedef enum logic [2:0] {
        EMPTY,
        INIT,
        ARM,
        RUN,
        PEND
    } state_t;
endpackage

// File: rtl/pwm_cfg_check.sv
// Combinational legality check and active-threshold clamp for a host setting.
// Optional feature macro: PWM_CLAMP_EN (clamp active to period instead of rejecting).
module pwm_cfg_check
    import pwm_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] active,
    output logic             legal,
    output logic [WIDTH-1:0] active_fix
);
    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

    logic period_ok;
    logic active_ok;

    assign period_ok = (period >= MIN_P);
    assign active_ok = (active <= period);

`ifdef PWM_CLAMP_EN
    // Over-range active means 100% duty rather than an error.
    assign legal      = period_ok;
    assign active_fix = active_ok ? active : period;
`else
    assign legal      = period_ok && active_ok;
    assign active_fix = active;
`endif
endmodule

// File: rtl/pwm_config_loader.sv
// Host-facing loader: checks {period, active}, shadows one setting and commits it at is_eq0.
// Optional feature macro: PWM_CLAMP_EN (handled inside pwm_cfg_check).
module pwm_config_loader
    import pwm_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_active,
    input  logic             is_eq0,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] active_out,
    output logic             load_reg,
    output logic             start_cnt,
    output logic             cfg_err,
    output logic             cfg_pend
);
    state_t           state, state_d;
    logic [WIDTH-1:0] shadow_p, shadow_p_d;
    logic [WIDTH-1:0] shadow_a, shadow_a_d;
    logic [WIDTH-1:0] period_d, active_d;
    logic             load_d, start_d, err_d, pend_d;
    logic             legal;
    logic [WIDTH-1:0] active_fix;
    logic             xfer;

    pwm_cfg_check #(
        .WIDTH      (WIDTH),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_check (
        .period     (cfg_period),
        .active     (cfg_active),
        .legal      (legal),
        .active_fix (active_fix)
    );

    assign cfg_ready = (state == EMPTY) || (state == RUN);
    assign xfer      = cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state;
        shadow_p_d = shadow_p;
        shadow_a_d = shadow_a;
        period_d   = period_out;
        active_d   = active_out;
        load_d     = 1'b0;
        start_d    = 1'b0;
        err_d      = 1'b0;
        pend_d     = cfg_pend;
        case (state)
            EMPTY: begin
                if (xfer) begin
                    if (legal) begin
                        // Outputs take the setting on the same edge so INIT presents it with load_reg.
                        shadow_p_d = cfg_period;
                        shadow_a_d = active_fix;
                        period_d   = cfg_period;
                        active_d   = active_fix;
                        load_d     = 1'b1;
                        state_d    = INIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            INIT: begin
                start_d = 1'b1;
                state_d = ARM;
            end
            ARM: begin
                state_d = RUN;
            end
            RUN: begin
                // is_eq0 is ignored here, so a same-cycle transfer waits for the next boundary.
                if (xfer) begin
                    if (legal) begin
                        shadow_p_d = cfg_period;
                        shadow_a_d = active_fix;
                        pend_d     = 1'b1;
                        state_d    = PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (is_eq0) begin
                    period_d = shadow_p;
                    active_d = shadow_a;
                    load_d   = 1'b1;
                    pend_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            shadow_p   <= '0;
            shadow_a   <= '0;
            period_out <= '0;
            active_out <= '0;
            load_reg   <= 1'b0;
            start_cnt  <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_pend   <= 1'b0;
        end else begin
            state      <= state_d;
            shadow_p   <= shadow_p_d;
            shadow_a   <= shadow_a_d;
            period_out <= period_d;
            active_out <= active_d;
            load_reg   <= load_d;
            start_cnt  <= start_d;
            cfg_err    <= err_d;
            cfg_pend   <= pend_d;
        end
    end
endmodule

// File: tb/tb_pwm_config_loader.sv
// Scoreboard bench for pwm_config_loader: directed scenarios followed by random traffic.
module tb_pwm_config_loader;
    localparam int W    = 16;
    localparam int MINP = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid, cfg_ready, is_eq0;
    logic [W-1:0] cfg_period, cfg_active, period_out, active_out;
    logic         load_reg, start_cnt, cfg_err, cfg_pend;

    pwm_config_loader #(.WIDTH(W), .MIN_PERIOD(MINP)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_active (cfg_active),
        .is_eq0     (is_eq0),
        .period_out (period_out),
        .active_out (active_out),
        .load_reg   (load_reg),
        .start_cnt  (start_cnt),
        .cfg_err    (cfg_err),
        .cfg_pend   (cfg_pend)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int stamp;
        bit ld;
        bit st;
        bit er;
        int p;
        int a;
    } ev_t;
    ev_t sbq[$];

    // Abstract model: configured yet, cycles left in start-up, one pending slot, committed outputs.
    bit m_cfgd  = 0;
    int m_start = 0;
    bit m_pend  = 0;
    int m_sh_p  = 0, m_sh_a = 0;
    int m_out_p = 0, m_out_a = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_legal(int p, int a);
`ifdef PWM_CLAMP_EN
        return (p >= MINP);
`else
        return (p >= MINP) && (a <= p);
`endif
    endfunction

    function automatic int m_fix(int p, int a);
`ifdef PWM_CLAMP_EN
        return (a > p) ? p : a;
`else
        return a;
`endif
    endfunction

    function automatic bit m_ready();
        return !m_cfgd || (m_start == 0 && !m_pend);
    endfunction

    // One clock cycle: check current state against the model, drive inputs, predict the next edge.
    task automatic step(bit v, int p, int a, bit e);
        ev_t ev;
        bit  rdy;
        @(negedge clk);
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
        chk("cfg_pend", 32'(cfg_pend), 32'(m_pend));
        chk("period_out", 32'(period_out), 32'(m_out_p));
        chk("active_out", 32'(active_out), 32'(m_out_a));
        cfg_valid  = v;
        cfg_period = W'(p);
        cfg_active = W'(a);
        is_eq0     = e;
        rdy = m_ready();
        ev  = '{stamp: cyc + 1, ld: 0, st: 0, er: 0, p: 0, a: 0};
        if (!m_cfgd) begin
            if (v) begin
                if (m_legal(p, a)) begin
                    m_cfgd = 1; m_start = 2; m_out_p = p; m_out_a = m_fix(p, a); ev.ld = 1;
                end else ev.er = 1;
            end
        end else if (m_start == 2) begin
            m_start = 1; ev.st = 1;
        end else if (m_start == 1) begin
            m_start = 0;
        end else if (m_pend) begin
            if (e) begin
                m_out_p = m_sh_p; m_out_a = m_sh_a; m_pend = 0; ev.ld = 1;
            end
        end else if (v && rdy) begin
            if (m_legal(p, a)) begin
                m_pend = 1; m_sh_p = p; m_sh_a = m_fix(p, a);
            end else ev.er = 1;
        end
        if (ev.ld || ev.st || ev.er) begin
            ev.p = m_out_p; ev.a = m_out_a;
            sbq.push_back(ev);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst period_out", 32'(period_out), 0);
        chk("rst active_out", 32'(active_out), 0);
        chk("rst load_reg", 32'(load_reg), 0);
        chk("rst start_cnt", 32'(start_cnt), 0);
        chk("rst cfg_err", 32'(cfg_err), 0);
        chk("rst cfg_pend", 32'(cfg_pend), 0);
        chk("rst cfg_ready", 32'(cfg_ready), 1);
        m_cfgd = 0; m_start = 0; m_pend = 0;
        m_sh_p = 0; m_sh_a = 0; m_out_p = 0; m_out_a = 0;
        sbq.delete();
        cfg_valid = 1'b0;
        is_eq0    = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Monitor: any pulse output must match the scoreboard entry stamped for this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sbq.size() > 0 && sbq[0].stamp == cyc) begin
                ev_t ev;
                ev = sbq.pop_front();
                chk("load_reg", 32'(load_reg), 32'(ev.ld));
                chk("start_cnt", 32'(start_cnt), 32'(ev.st));
                chk("cfg_err", 32'(cfg_err), 32'(ev.er));
                if (ev.ld) begin
                    chk("load period", 32'(period_out), 32'(ev.p));
                    chk("load active", 32'(active_out), 32'(ev.a));
                end
            end else if (load_reg || start_cnt || cfg_err) begin
                chk("unexpected pulse", {29'd0, load_reg, start_cnt, cfg_err}, 0);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_active = '0;
        is_eq0     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset period_out", 32'(period_out), 0);
        chk("reset load_reg", 32'(load_reg), 0);
        #2 rst_n = 1'b1;

        // First setting: load then start pulse.
        step(1, 100, 40, 0);
        repeat (3) step(0, 0, 0, 0);
        // Pending setting held until boundary.
        step(1, 200, 50, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        // Period below minimum, and active above period.
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 50, 80, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // Boundary coincident with the transfer is not used.
        step(1, 300, 10, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // Reset while pending, then stay idle: no start pulse may appear.
        step(1, 120, 60, 0);
        step(0, 0, 0, 0);
        do_reset();
        repeat (5) step(0, 0, 0, 1);
        step(1, MINP, MINP, 0);
        repeat (3) step(0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int p, a;
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(2, 500);
            a = $urandom_range(0, p + p / 2 + 1);
            step($urandom_range(0, 2) != 0, p, a, $urandom_range(0, 3) == 0);
            if (i == 300) do_reset();
        end
        repeat (3) step(0, 0, 0, 0);
        chk("scoreboard drained", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
